// File: rtl/pe_acc_sched.sv
// Sequencer for a VECTOR-lane MAC PE: streams K operand beats into the PE, feeds
// its output back as the accumulator, and returns the lane sums on a valid/ready handshake.
module pe_acc_sched #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 6,
  parameter int KW        = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_start,
  input  logic [KW-1:0]                       i_k_len,
  output logic                                o_busy,
  output logic                                o_done,
  input  logic                                i_op_valid,
  output logic                                o_op_ready,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]    i_op_a,
  input  logic [REG_WIDTH-1:0]                i_op_b,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    o_pe_a_n_1,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    o_pe_b_n_1,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    o_pe_c_n_1,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]    i_pe_c_ab,
  output logic                                o_res_valid,
  input  logic                                i_res_ready,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]    o_res_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t                          r_state;
  state_t                          w_nextState;
  logic [KW-1:0]                   r_kLen;
  logic [KW-1:0]                   r_count;
  logic                            r_first;
  logic                            r_done;
  logic [VECTOR-1:0][REG_WIDTH-1:0] r_resData;
  logic                            w_beat;
  logic                            w_lastBeat;

  assign o_op_ready  = (r_state == S_RUN);
  assign o_busy      = (r_state != S_IDLE);
  assign o_res_valid = (r_state == S_RESULT);
  assign o_res_data  = r_resData;
  assign o_done      = r_done;
  assign w_beat      = i_op_valid & o_op_ready;
  assign w_lastBeat  = (r_count == (r_kLen - KW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // r_first keeps the PE accumulator input at zero until the first real beat,
  // so whatever the PE left behind from an aborted job never leaks in.
  always_comb begin
    w_nextState = r_state;
    o_pe_a_n_1  = '0;
    o_pe_b_n_1  = '0;
    o_pe_c_n_1  = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = (i_k_len != '0) ? S_RUN : S_RESULT;
        end
      end
      S_RUN: begin
        if (w_beat) begin
          o_pe_a_n_1 = i_op_a;
          for (int i = 0; i < VECTOR; i++) begin
            o_pe_b_n_1[i] = i_op_b;
          end
          if (w_lastBeat) begin
            w_nextState = S_DRAIN;
          end
        end
        if (!r_first) begin
          o_pe_c_n_1 = i_pe_c_ab;
        end
      end
      S_DRAIN: begin
        o_pe_c_n_1  = i_pe_c_ab;
        w_nextState = S_RESULT;
      end
      S_RESULT: begin
        if (i_res_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kLen    <= '0;
      r_count   <= '0;
      r_first   <= 1'b1;
      r_done    <= 1'b0;
      r_resData <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_kLen  <= i_k_len;
            r_count <= '0;
            r_first <= 1'b1;
            if (i_k_len == '0) begin
              r_resData <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_beat) begin
            r_count <= r_count + KW'(1);
            r_first <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_resData <= i_pe_c_ab;
        end
        S_RESULT: begin
          if (i_res_ready) begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_first <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_acc_sched.sv
// Scoreboard bench for pe_acc_sched with a behavioural registered MAC PE attached;
// expected sums are computed from the driven operands and queued per job.
module tb_pe_acc_sched;

  localparam int RW  = 16;
  localparam int VEC = 6;
  localparam int KW  = 8;

  typedef logic [VEC-1:0][RW-1:0] vec_t;
  typedef struct {
    vec_t data;
    int   lat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [KW-1:0] i_k_len;
  logic          o_busy;
  logic          o_done;
  logic          i_op_valid;
  logic          o_op_ready;
  vec_t          i_op_a;
  logic [RW-1:0] i_op_b;
  vec_t          o_pe_a_n_1;
  vec_t          o_pe_b_n_1;
  vec_t          o_pe_c_n_1;
  vec_t          peCab;
  logic          o_res_valid;
  logic          i_res_ready;
  vec_t          o_res_data;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbQ[$];
  vec_t aBeat[8];
  logic [RW-1:0] bBeat[8];
  bit   validPat[16];
  int   patLen;

  pe_acc_sched #(.REG_WIDTH(RW), .VECTOR(VEC), .KW(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_k_len    (i_k_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .i_op_valid (i_op_valid),
    .o_op_ready (o_op_ready),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .o_pe_a_n_1 (o_pe_a_n_1),
    .o_pe_b_n_1 (o_pe_b_n_1),
    .o_pe_c_n_1 (o_pe_c_n_1),
    .i_pe_c_ab  (peCab),
    .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready),
    .o_res_data (o_res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural PE: registered a*b+c per lane, no reset, truncated to RW bits.
  always @(posedge clk) begin
    for (int l = 0; l < VEC; l++) begin
      peCab[l] <= o_pe_a_n_1[l] * o_pe_b_n_1[l] + o_pe_c_n_1[l];
    end
  end

  task automatic driveJob(input int k, output int c0, output int bubbleBad);
    exp_t e;
    int   ones, zeros, p, beat, guard;
    bit   v, rdy;
    e.data = '0;
    for (int j = 0; j < k; j++) begin
      for (int l = 0; l < VEC; l++) begin
        e.data[l] = e.data[l] + aBeat[j][l] * bBeat[j];
      end
    end
    ones = 0; zeros = 0; p = 0;
    while (ones < k) begin
      if (p < patLen && !validPat[p]) zeros++;
      else ones++;
      p++;
    end
    e.lat = k + 2 + zeros;
    sbQ.push_back(e);
    i_start = 1'b1;
    i_k_len = KW'(k);
    @(posedge clk); #1;
    c0 = cyc;
    i_start = 1'b0;
    bubbleBad = 0; beat = 0; p = 0; guard = 0;
    while (beat < k && guard < 200) begin
      v = (p < patLen) ? validPat[p] : 1'b1;
      i_op_valid = v;
      if (v) begin
        i_op_a = aBeat[beat];
        i_op_b = bBeat[beat];
      end else begin
        i_op_a = {VEC{16'hDEAD}};
        i_op_b = 16'hBEEF;
      end
      #1;
      rdy = o_op_ready;
      if (!v && (o_pe_a_n_1 !== '0 || o_pe_b_n_1 !== '0)) bubbleBad++;
      @(posedge clk); #1;
      if (v && rdy) beat++;
      p++; guard++;
    end
    i_op_valid = 1'b0;
    i_op_a = '0;
    i_op_b = '0;
  endtask

  task automatic waitResult(output bit ok, output int cycObs);
    ok = 1'b0;
    cycObs = -1;
    for (int i = 0; i < 100; i++) begin
      if (o_res_valid === 1'b1) begin
        ok = 1'b1;
        cycObs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_op_a = {VEC{16'h1111}};
    i_op_b = 16'h2222;
    i_op_valid = 1'b1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", o_busy); end
    total++; if (o_op_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_op_ready: got %0b want 0", o_op_ready); end
    total++; if (o_res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_res_valid: got %0b want 0", o_res_valid); end
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0b want 0", o_done); end
    total++; if (o_res_data !== '0) begin bad++; $display("[TB] FAIL reset_res_data: got %h want 0", o_res_data); end
    total++; if (o_pe_a_n_1 !== '0) begin bad++; $display("[TB] FAIL reset_pe_a: got %h want 0", o_pe_a_n_1); end
    total++; if (o_pe_b_n_1 !== '0) begin bad++; $display("[TB] FAIL reset_pe_b: got %h want 0", o_pe_b_n_1); end
    total++; if (o_pe_c_n_1 !== '0) begin bad++; $display("[TB] FAIL reset_pe_c: got %h want 0", o_pe_c_n_1); end
    i_op_valid = 1'b0;
    i_op_a = '0;
    i_op_b = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic checkJob(input string name, input int c0);
    bit   ok;
    int   co;
    exp_t e;
    waitResult(ok, co);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got no res_valid want res_valid within 100 cycles", name);
    end
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (ok) begin
        total++;
        if (o_res_data !== e.data) begin bad++; $display("[TB] FAIL %s_data: got %h want %h", name, o_res_data, e.data); end
        total++;
        if (co - c0 + 1 !== e.lat) begin bad++; $display("[TB] FAIL %s_latency: got %0d want %0d", name, co - c0 + 1, e.lat); end
      end
    end
    handshake();
    total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL %s_done_pulse: got %0b want 1", name, o_done); end
    @(posedge clk); #1;
    total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL %s_done_clear: got %0b want 0", name, o_done); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL %s_idle: got busy=%0b want 0", name, o_busy); end
  endtask

  task automatic test_basic();
    int c0, bb;
    for (int j = 0; j < 3; j++) begin
      for (int l = 0; l < VEC; l++) aBeat[j][l] = RW'(l + 1);
      bBeat[j] = RW'(j + 2);
    end
    patLen = 0;
    driveJob(3, c0, bb);
    checkJob("basic", c0);
  endtask

  task automatic test_stall();
    int c0, bb;
    validPat[0] = 1; validPat[1] = 0; validPat[2] = 0;
    validPat[3] = 1; validPat[4] = 0; validPat[5] = 1;
    patLen = 6;
    driveJob(3, c0, bb);
    total++; if (bb !== 0) begin bad++; $display("[TB] FAIL stall_bubble_zero: got %0d nonzero bubbles want 0", bb); end
    checkJob("stall", c0);
    patLen = 0;
  endtask

  task automatic test_wrap();
    int c0, bb;
    aBeat[0] = {VEC{16'hFFFF}};
    bBeat[0] = 16'd2;
    patLen = 0;
    driveJob(1, c0, bb);
    checkJob("wrap", c0);
  endtask

  task automatic test_zero_len();
    exp_t e;
    e.data = '0;
    e.lat  = 2;
    sbQ.push_back(e);
    i_start = 1'b1;
    i_k_len = '0;
    @(posedge clk); #1;
    i_k_len = 8'd5;
    total++; if (o_res_valid !== 1'b1) begin bad++; $display("[TB] FAIL zero_valid: got %0b want 1", o_res_valid); end
    e = sbQ.pop_front();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (o_res_valid !== 1'b1) begin bad++; $display("[TB] FAIL zero_hold_valid: got %0b want 1", o_res_valid); end
      total++; if (o_res_data !== e.data) begin bad++; $display("[TB] FAIL zero_hold_data: got %h want %h", o_res_data, e.data); end
      total++; if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL zero_early_done: got %0b want 0", o_done); end
    end
    i_start = 1'b0;
    handshake();
    total++; if (o_done !== 1'b1) begin bad++; $display("[TB] FAIL zero_done_pulse: got %0b want 1", o_done); end
    @(posedge clk); #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_idle: got busy=%0b want 0", o_busy); end
    total++; if (o_op_ready !== 1'b0) begin bad++; $display("[TB] FAIL zero_start_ignored: got op_ready=%0b want 0", o_op_ready); end
  endtask

  task automatic test_reset_midrun();
    int c0, bb;
    i_start = 1'b1;
    i_k_len = 8'd4;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      i_op_valid = 1'b1;
      for (int l = 0; l < VEC; l++) i_op_a[l] = RW'($urandom_range(1, 1000));
      i_op_b = RW'($urandom_range(1, 1000));
      @(posedge clk); #1;
    end
    i_op_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    total++; if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %0b want 0", o_busy); end
    total++; if (o_op_ready !== 1'b0) begin bad++; $display("[TB] FAIL abort_op_ready: got %0b want 0", o_op_ready); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    aBeat[0] = {VEC{16'd5}};
    bBeat[0] = 16'd5;
    patLen = 0;
    driveJob(1, c0, bb);
    checkJob("after_abort", c0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_k_len = '0;
    i_op_valid = 1'b0;
    i_op_a = '0;
    i_op_b = '0;
    i_res_ready = 1'b0;
    patLen = 0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_len();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
